addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial.sv | 141 ++++++++++++++
 tb/tb_addsub_serial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Chunk-serial adder/subtractor.
// Operands are captured on start and combined CHUNK bits per clock, LSB
// chunk first, through a single CHUNK-bit adder with a carry flop between
// chunks. Flags (carry, overflow, zero) are published when the last chunk
// lands, and all results hold until the next accepted start.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  // Keep the chunk index at least one bit wide so N == 1 still elaborates.
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;        // effective operand: b or ~b
  logic [KW-1:0]      k_q, k_d;        // index of the chunk processed next
  logic               cr_q, cr_d;      // carry between chunks
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_res;
  logic               last_chunk;

  // Chunk datapath: select chunk k of both operands and add with the running carry.
  always_comb begin
    a_chunk    = a_q[int'(k_q) * CHUNK +: CHUNK];
    b_chunk    = b_q[int'(k_q) * CHUNK +: CHUNK];
    chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cr_q};
    last_chunk = (k_q == KW'(N - 1));
  end

  // Next-state and datapath update: capture in IDLE, one chunk per RUN cycle,
  // flags published together with the final chunk.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cr_d    = cr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtract is a + ~b + 1, so the carry-in is forced to 1 and cin is ignored.
          b_d     = mode ? ~b : b;
          cr_d    = mode ? 1'b1 : cin;
          k_d     = '0;
          sum_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(k_q) * CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        cr_d = chunk_res[CHUNK];
        if (last_chunk) begin
          k_d     = '0;
          carry_d = chunk_res[CHUNK];
          // The top bit of the final chunk is the sum MSB.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (chunk_res[CHUNK-1] != a_q[WIDTH-1]);
          zero_d  = (sum_d == '0);
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset that overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cr_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cr_q    <= cr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (16/4, 8/8, 32/8) sharing the
// operand buses, each with its own start strobe.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic        mode;
  logic        cin;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic        busy16, done16, carry16, ovf16, zero16;
  logic [15:0] sum16;
  logic        busy8, done8, carry8, ovf8, zero8;
  logic [7:0]  sum8;
  logic        busy32, done32, carry32, ovf32, zero32;
  logic [31:0] sum32;

  int          cur;
  logic        busy_s, done_s, carry_s, ovf_s, zero_s;
  logic [31:0] sum_s;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16),
    .overflow(ovf16), .zero(zero16)
  );

  addsub_serial #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8),
    .overflow(ovf8), .zero(zero8)
  );

  addsub_serial #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode),
    .a(a_in), .b(b_in), .cin(cin),
    .busy(busy32), .done(done32), .sum(sum32), .carry(carry32),
    .overflow(ovf32), .zero(zero32)
  );

  // Route the outputs of the instance under test to one set of signals.
  always_comb begin
    busy_s = busy16; done_s = done16; carry_s = carry16; ovf_s = ovf16;
    zero_s = zero16; sum_s = {16'h0, sum16};
    case (cur)
      1: begin
        busy_s = busy8; done_s = done8; carry_s = carry8; ovf_s = ovf8;
        zero_s = zero8; sum_s = {24'h0, sum8};
      end
      2: begin
        busy_s = busy32; done_s = done32; carry_s = carry32; ovf_s = ovf32;
        zero_s = zero32; sum_s = sum32;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        m;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] es;
    logic        ec;
    logic        ev;
    logic        ez;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Full transaction: start, N busy cycles, one done cycle with results, held after.
  task automatic run_op(input int inst, input string tag, input logic m,
                        input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input logic [31:0] es, input logic ec, input logic ev, input logic ez);
    int n;
    n = (inst == 1) ? 1 : 4;
    @(negedge clk);
    cur = inst; a_in = av; b_in = bv; mode = m; cin = ci;
    start_v = 3'b000;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v = 3'b000;
    for (int i = 0; i < n; i++) begin
      chk({tag, " busy"}, {31'b0, busy_s}, 32'd1);
      chk({tag, " early done"}, {31'b0, done_s}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, " done"}, {30'b0, busy_s, done_s}, 32'd1);
    chk({tag, " sum"}, sum_s, es);
    chk({tag, " flags"}, {29'b0, carry_s, ovf_s, zero_s}, {29'b0, ec, ev, ez});
    @(posedge clk); #1;
    chk({tag, " done cleared"}, {30'b0, busy_s, done_s}, 32'd0);
    chk({tag, " sum held"}, sum_s, es);
    $display("op %s inst=%0d mode=%0b a=%0h b=%0h cin=%0b -> sum=%0h c=%0b v=%0b z=%0b",
             tag, inst, m, av, bv, ci, sum_s, carry_s, ovf_s, zero_s);
  endtask

  initial begin
    logic [32:0] wide;
    logic [31:0] ra, rb, rbe;
    logic        rm, rci;
    int          dones;

    vecs[0]  = '{1'b0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'h7FFF, 32'h0000, 1'b1, 32'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h0005, 32'h0007, 1'b0, 32'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h1234, 32'h1234, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 32'h0010, 32'h0001, 1'b1, 32'h000F, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h00FF, 32'h0001, 1'b1, 32'h0101, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1, 1'b0, 1'b0};

    cur = 0; rst_n = 1'b0; start_v = 3'b000; mode = 1'b0; cin = 1'b0;
    a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {26'b0, busy_s, done_s, carry_s, ovf_s, zero_s, 1'b0}, 32'd0);
    chk("reset sum", sum_s, 32'd0);
    rst_n = 1'b1;

    // Directed table on the 16/4 instance.
    for (int i = 0; i < 11; i++)
      run_op(0, $sformatf("v%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].ci,
             vecs[i].es, vecs[i].ec, vecs[i].ev, vecs[i].ez);

    // Re-pulsed start and operand changes during RUN must not disturb the result.
    @(negedge clk);
    cur = 0; a_in = 32'h1234; b_in = 32'h4321; mode = 1'b0; cin = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000; a_in = 32'hFFFF; b_in = 32'hFFFF; mode = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("disturb done", {31'b0, done_s}, 32'd1);
    chk("disturb sum", sum_s, 32'h5555);
    chk("disturb flags", {29'b0, carry_s, ovf_s, zero_s}, 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_s || busy_s) dones++;
    end
    chk("disturb extra activity", dones, 0);
    $display("op disturb -> sum=%0h extra_cycles=%0d", sum_s, dones);

    // Reset at edge t+2 mid-RUN, with start asserted under reset.
    @(negedge clk);
    cur = 0; a_in = 32'h1234; b_in = 32'h4321; mode = 1'b0; cin = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    chk("midrun reset flags", {27'b0, busy_s, done_s, carry_s, ovf_s, zero_s}, 32'd0);
    chk("midrun reset sum", sum_s, 32'd0);
    rst_n = 1'b1; start_v = 3'b000;
    @(posedge clk); #1;
    chk("start under reset ignored", {31'b0, busy_s}, 32'd0);
    $display("op midrun reset -> busy=%0b sum=%0h", busy_s, sum_s);
    run_op(0, "after reset", 1'b0, 32'h0F0F, 32'h0101, 1'b0, 32'h1010, 1'b0, 1'b0, 1'b0);

    // Single-chunk configuration.
    run_op(1, "w8 add", 1'b0, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
    run_op(1, "w8 sub", 1'b1, 32'h10, 32'h20, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b0);

    // Random 32/8 operations against a 33-bit arithmetic model.
    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rm  = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      rbe = rm ? ~rb : rb;
      wide = {1'b0, ra} + {1'b0, rbe} + {32'b0, (rm ? 1'b1 : rci)};
      run_op(2, $sformatf("r%0d", i), rm, ra, rb, rci, wide[31:0], wide[32],
             (ra[31] == rbe[31]) && (wide[31] != ra[31]), (wide[31:0] == 32'd0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
